// File: rtl/mtsp_wb_pkg.sv
// Shared types and constants for the MTSP writeback queue.
// Optional same-cycle bypass is enabled by defining MTSP_WB_BYPASS_EN.
package mtsp_wb_pkg;

    localparam int WB_DATA_W = 128;
    localparam int WB_MASK_W = 4;
    // Storage width for destination indices; the top requires ADDR_W <= WB_DST_W.
    localparam int WB_DST_W  = 16;

    localparam logic [WB_MASK_W-1:0] WB_MASK_ALLMASKED = 4'b1111;

    typedef struct packed {
        logic [WB_DST_W-1:0]  dst;
        logic [WB_MASK_W-1:0] mask;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/mtsp_wb_fifo.sv
// Circular entry store with occupancy count and per-slot validity.
// Optional same-cycle bypass is enabled by defining MTSP_WB_BYPASS_EN.
module mtsp_wb_fifo
    import mtsp_wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             push,
    input  logic                             pop,
    input  wb_entry_t                        wr_data,
    output wb_entry_t                        rd_data,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic [DEPTH-1:0][WB_DST_W-1:0]   slot_dst,
    output logic [DEPTH-1:0]                 slot_valid
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    wb_entry_t       mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Contents need no reset; validity is derived from pointers and count.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        logic [PW-1:0] off;
        assign off           = PW'(i) - rd_ptr;
        assign slot_valid[i] = CW'(off) < count;
        assign slot_dst[i]   = mem[i].dst;
    end

endmodule

// File: rtl/mtsp_writeback_queue.sv
// Writeback queue between EW1 and the register-file write port.
// Optional same-cycle bypass is enabled by defining MTSP_WB_BYPASS_EN.
module mtsp_writeback_queue
    import mtsp_wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 6
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EW1_nEN,
    input  logic [3:0]           EW1_MASK,
    input  logic [127:0]         EW1_DATA,
    input  logic [ADDR_W-1:0]    EW1_DST,
    output logic                 EW1_STALL,
    input  logic                 RF_GRANT,
    output logic                 RF_nWE,
    output logic [ADDR_W-1:0]    RF_ADDR,
    output logic [3:0]           RF_MASK,
    output logic [127:0]         RF_DATA,
    input  logic [ADDR_W-1:0]    QUERY_ADDR,
    output logic                 QUERY_HIT,
    output logic                 OVERFLOW
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] NEAR_FULL = CW'(DEPTH - 1);

    wb_entry_t                      in_entry;
    wb_entry_t                      head;
    logic [CW-1:0]                  count;
    logic [DEPTH-1:0][WB_DST_W-1:0] slot_dst;
    logic [DEPTH-1:0]               slot_valid;
    logic                           req;
    logic                           pop;
    logic                           byp;
    logic                           push;

    assign in_entry.dst  = WB_DST_W'(EW1_DST);
    assign in_entry.mask = EW1_MASK;
    assign in_entry.data = EW1_DATA;

    assign req = !EW1_nEN && (EW1_MASK != WB_MASK_ALLMASKED);
    assign pop = (count != '0) && RF_GRANT;

`ifdef MTSP_WB_BYPASS_EN
    assign byp = req && (count == '0) && RF_GRANT;
`else
    assign byp = 1'b0;
`endif

    // A full queue still accepts when the head drains in the same cycle.
    assign push = req && !byp && ((count != FULL) || pop);

    mtsp_wb_fifo #(
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk        (CLK),
        .rst        (RST),
        .push       (push),
        .pop        (pop),
        .wr_data    (in_entry),
        .rd_data    (head),
        .count      (count),
        .slot_dst   (slot_dst),
        .slot_valid (slot_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST)
            OVERFLOW <= 1'b0;
        else if (req && (count == FULL) && !pop)
            OVERFLOW <= 1'b1;
    end

    always_comb begin
        RF_nWE  = 1'b1;
        RF_ADDR = '0;
        RF_MASK = WB_MASK_ALLMASKED;
        RF_DATA = '0;
        if (pop) begin
            RF_nWE  = 1'b0;
            RF_ADDR = ADDR_W'(head.dst);
            RF_MASK = head.mask;
            RF_DATA = head.data;
        end else if (byp) begin
            RF_nWE  = 1'b0;
            RF_ADDR = EW1_DST;
            RF_MASK = EW1_MASK;
            RF_DATA = EW1_DATA;
        end
    end

    assign EW1_STALL = count >= NEAR_FULL;

    always_comb begin
        QUERY_HIT = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (slot_valid[i] && (slot_dst[i] == WB_DST_W'(QUERY_ADDR)))
                QUERY_HIT = 1'b1;
        end
    end

endmodule
